// File: rtl/trace_ring_buffer_pkg.sv
// Shared types and sizing for the trace ring buffer: word width, default depth
// and the controller state encoding.
package trace_ring_buffer_pkg;
  localparam int TRB_WIDTH     = 32;
  localparam int TRB_POS_BITS  = $clog2(TRB_WIDTH);
  localparam int TRB_DEPTH     = 64;
  localparam int TRB_ADDR_BITS = $clog2(TRB_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    POST,
    DONE,
    STREAM
  } trb_state_t;
endpackage

// File: rtl/trace_ring_buffer_bram.sv
// Simple dual-port synchronous RAM: one write port, one registered read port,
// no reset so it maps onto block RAM. Read-during-write returns the old word.
module trace_bram #(
  parameter int AW = 6,
  parameter int W  = 32
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);
  logic [W-1:0] mem_q [2**AW];
  logic [W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/trace_ring_buffer.sv
// Trace memory behind the Tracer: trigger-aware capture ring with host readout,
// or a host-filled FIFO drained by Tracer requests.
module trace_ring_buffer
  import trace_ring_buffer_pkg::*;
#(
  parameter  int DEPTH = TRB_DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                    CLK_I,
  input  logic                    RST_NI,
  input  logic                    EN_I,
  input  logic                    MODE_I,
  input  logic [AW-1:0]           TRG_DELAY_I,
  input  logic                    STORE_I,
  input  logic [TRB_WIDTH-1:0]    DATA_I,
  input  logic                    TRG_EVENT_I,
  input  logic [TRB_POS_BITS-1:0] EVENT_POS_I,
  input  logic                    REQ_I,
  output logic [TRB_WIDTH-1:0]    DATA_O,
  output logic                    LOAD_O,
  input  logic                    HOST_WVALID_I,
  input  logic [TRB_WIDTH-1:0]    HOST_WDATA_I,
  output logic                    HOST_WREADY_O,
  output logic                    HOST_RVALID_O,
  output logic [TRB_WIDTH-1:0]    HOST_RDATA_O,
  input  logic                    HOST_RREADY_I,
  output logic                    DONE_O,
  output logic [AW-1:0]           TRG_ADDR_O,
  output logic [TRB_POS_BITS-1:0] TRG_POS_O,
  output logic                    WRAPPED_O,
  output logic                    UNDERRUN_O
);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE  = (AW+1)'(1);

  trb_state_t state_q, state_d;

  logic [AW-1:0]           wp_q, wp_d, rp_q, rp_d;
  logic [AW-1:0]           trg_addr_q, trg_addr_d, post_cnt_q, post_cnt_d;
  logic [AW:0]             fill_q, fill_d, cnt_q, cnt_d, rem_q, rem_d;
  logic [TRB_POS_BITS-1:0] trg_pos_q, trg_pos_d;
  logic                    wrapped_q, wrapped_d, underrun_q, underrun_d;
  logic                    req_pend_q, req_pend_d, load_q, load_d;
  logic [TRB_WIDTH-1:0]    data_q, data_d;
  logic                    fwd_vld_q;
  logic [AW-1:0]           fwd_addr_q;
  logic [TRB_WIDTH-1:0]    fwd_data_q;

  logic                    we;
  logic [AW-1:0]           waddr;
  logic [TRB_WIDTH-1:0]    wdata, ram_rdata, rd_word;
  logic                    rvalid, wready, push, pop, req_act;

  // Read address follows the next read pointer, so ram_rdata always holds
  // mem[rp_q] one cycle later: the RAM latency is prefetched away.
  trace_bram #(.AW(AW), .W(TRB_WIDTH)) u_bram (
    .clk_i   (CLK_I),
    .we_i    (we),
    .waddr_i (waddr),
    .wdata_i (wdata),
    .raddr_i (rp_d),
    .rdata_o (ram_rdata)
  );

  // A word written on the same edge it was fetched comes back stale from the
  // RAM; forward the last write instead.
  assign rd_word = (fwd_vld_q && fwd_addr_q == rp_q) ? fwd_data_q : ram_rdata;

  always_ff @(posedge CLK_I) begin
    if (!RST_NI || !EN_I) state_q <= IDLE;
    else                  state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (EN_I) state_d = MODE_I ? STREAM : ARMED;
      ARMED:   if (STORE_I && TRG_EVENT_I) state_d = (TRG_DELAY_I == '0) ? DONE : POST;
      POST:    if (STORE_I && post_cnt_q == AW'(1)) state_d = DONE;
      default: ;
    endcase
  end

  always_comb begin
    wp_d       = wp_q;
    rp_d       = rp_q;
    fill_d     = fill_q;
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    post_cnt_d = post_cnt_q;
    trg_addr_d = trg_addr_q;
    trg_pos_d  = trg_pos_q;
    wrapped_d  = wrapped_q;
    underrun_d = underrun_q;
    req_pend_d = req_pend_q;
    load_d     = 1'b0;
    data_d     = data_q;
    we         = 1'b0;
    waddr      = wp_q;
    wdata      = DATA_I;
    push       = 1'b0;
    pop        = 1'b0;
    req_act    = 1'b0;
    case (state_q)
      ARMED, POST: begin
        if (STORE_I) begin
          we   = 1'b1;
          wp_d = wp_q + AW'(1);
          if (wp_q == AW'(DEPTH-1)) wrapped_d = 1'b1;
          if (fill_q != FULL) fill_d = fill_q + ONE;
          if (state_q == ARMED && TRG_EVENT_I) begin
            trg_addr_d = wp_q;
            trg_pos_d  = EVENT_POS_I;
            post_cnt_d = TRG_DELAY_I;
          end
          if (state_q == POST) post_cnt_d = post_cnt_q - AW'(1);
        end
        // Once wrapped, the oldest surviving word sits at the next write slot.
        if (state_d == DONE) begin
          rp_d  = wrapped_d ? wp_d : '0;
          rem_d = fill_d;
        end
      end
      DONE: begin
        if (rvalid && HOST_RREADY_I) begin
          rp_d  = rp_q + AW'(1);
          rem_d = rem_q - ONE;
        end
      end
      STREAM: begin
        push    = HOST_WVALID_I && wready;
        req_act = req_pend_q || (REQ_I && !load_q);
        pop     = req_act && (cnt_q != '0);
        if (push) begin
          we    = 1'b1;
          wdata = HOST_WDATA_I;
          wp_d  = wp_q + AW'(1);
        end
        if (pop) begin
          load_d     = 1'b1;
          data_d     = rd_word;
          rp_d       = rp_q + AW'(1);
          req_pend_d = 1'b0;
        end else if (req_act) begin
          req_pend_d = 1'b1;
          underrun_d = 1'b1;
        end
        if (push && !pop)      cnt_d = cnt_q + ONE;
        else if (pop && !push) cnt_d = cnt_q - ONE;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK_I) begin
    if (!RST_NI || !EN_I) begin
      wp_q       <= '0;
      rp_q       <= '0;
      fill_q     <= '0;
      cnt_q      <= '0;
      rem_q      <= '0;
      post_cnt_q <= '0;
      trg_addr_q <= '0;
      trg_pos_q  <= '0;
      wrapped_q  <= 1'b0;
      underrun_q <= 1'b0;
      req_pend_q <= 1'b0;
      load_q     <= 1'b0;
      data_q     <= '0;
      fwd_vld_q  <= 1'b0;
      fwd_addr_q <= '0;
      fwd_data_q <= '0;
    end else begin
      wp_q       <= wp_d;
      rp_q       <= rp_d;
      fill_q     <= fill_d;
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      post_cnt_q <= post_cnt_d;
      trg_addr_q <= trg_addr_d;
      trg_pos_q  <= trg_pos_d;
      wrapped_q  <= wrapped_d;
      underrun_q <= underrun_d;
      req_pend_q <= req_pend_d;
      load_q     <= load_d;
      data_q     <= data_d;
      fwd_vld_q  <= we;
      fwd_addr_q <= waddr;
      fwd_data_q <= wdata;
    end
  end

  always_comb begin
    rvalid        = (state_q == DONE) && (rem_q != '0);
    wready        = (state_q == STREAM) && (cnt_q != FULL);
    HOST_RVALID_O = rvalid;
    HOST_RDATA_O  = rvalid ? rd_word : '0;
    HOST_WREADY_O = wready;
    DONE_O        = (state_q == DONE);
    LOAD_O        = load_q;
    DATA_O        = data_q;
    TRG_ADDR_O    = trg_addr_q;
    TRG_POS_O     = trg_pos_q;
    WRAPPED_O     = wrapped_q;
    UNDERRUN_O    = underrun_q;
  end
endmodule

// File: tb/tb_trace_ring_buffer.sv
// Bench for trace_ring_buffer at DEPTH=8: capture vectors from a table, stream
// and corner sequences by hand, all data checked against scoreboard queues.
module tb_trace_ring_buffer;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic        CLK_I = 1'b0;
  logic        RST_NI, EN_I, MODE_I, STORE_I, TRG_EVENT_I, REQ_I;
  logic [AW-1:0] TRG_DELAY_I;
  logic [31:0] DATA_I, HOST_WDATA_I;
  logic [4:0]  EVENT_POS_I;
  logic        HOST_WVALID_I, HOST_RREADY_I;
  logic [31:0] DATA_O, HOST_RDATA_O;
  logic        LOAD_O, HOST_WREADY_O, HOST_RVALID_O, DONE_O, WRAPPED_O, UNDERRUN_O;
  logic [AW-1:0] TRG_ADDR_O;
  logic [4:0]  TRG_POS_O;

  trace_ring_buffer #(.DEPTH(DEPTH)) dut (
    .CLK_I(CLK_I), .RST_NI(RST_NI), .EN_I(EN_I), .MODE_I(MODE_I),
    .TRG_DELAY_I(TRG_DELAY_I), .STORE_I(STORE_I), .DATA_I(DATA_I),
    .TRG_EVENT_I(TRG_EVENT_I), .EVENT_POS_I(EVENT_POS_I), .REQ_I(REQ_I),
    .DATA_O(DATA_O), .LOAD_O(LOAD_O),
    .HOST_WVALID_I(HOST_WVALID_I), .HOST_WDATA_I(HOST_WDATA_I), .HOST_WREADY_O(HOST_WREADY_O),
    .HOST_RVALID_O(HOST_RVALID_O), .HOST_RDATA_O(HOST_RDATA_O), .HOST_RREADY_I(HOST_RREADY_I),
    .DONE_O(DONE_O), .TRG_ADDR_O(TRG_ADDR_O), .TRG_POS_O(TRG_POS_O),
    .WRAPPED_O(WRAPPED_O), .UNDERRUN_O(UNDERRUN_O)
  );

  always #5 CLK_I = ~CLK_I;

  typedef struct {
    logic [31:0] data;
    logic        trg;
    logic [4:0]  pos;
    logic        exp_done;
  } cap_vec_t;

  cap_vec_t    vt [5];
  logic [31:0] cap_q[$];
  logic [31:0] sb[$];
  int          n_chk = 0;
  int          n_bad = 0;

  task automatic tick();
    @(posedge CLK_I);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic start_mode(input logic m, input logic [AW-1:0] dly);
    EN_I = 1'b0;
    tick();
    MODE_I      = m;
    TRG_DELAY_I = dly;
    EN_I        = 1'b1;
    tick();
    cap_q.delete();
    sb.delete();
  endtask

  task automatic store_word(input logic [31:0] d, input logic trg, input logic [4:0] pos,
                            input bit model);
    STORE_I = 1'b1; DATA_I = d; TRG_EVENT_I = trg; EVENT_POS_I = pos;
    if (model) begin
      cap_q.push_back(d);
      if (cap_q.size() > DEPTH) void'(cap_q.pop_front());
    end
    tick();
    STORE_I = 1'b0; TRG_EVENT_I = 1'b0;
  endtask

  task automatic drain(input bit stall, input int budget);
    logic [31:0] prev = '0;
    bit          hold = 1'b0;
    bit          rr;
    int          cyc  = 0;
    while (cap_q.size() > 0 && cyc < budget) begin
      rr = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      HOST_RREADY_I = rr;
      if (hold) chk("rd_stable", HOST_RDATA_O, prev);
      if (HOST_RVALID_O && rr) chk("rd_data", HOST_RDATA_O, cap_q.pop_front());
      hold = HOST_RVALID_O && !rr;
      prev = HOST_RDATA_O;
      tick();
      cyc++;
    end
    HOST_RREADY_I = 1'b0;
    chk("rd_left", 32'(cap_q.size()), 32'd0);
    cap_q.delete();
  endtask

  task automatic push_word(input logic [31:0] d);
    HOST_WVALID_I = 1'b1; HOST_WDATA_I = d;
    if (HOST_WREADY_O) sb.push_back(d);
    tick();
    HOST_WVALID_I = 1'b0;
  endtask

  task automatic chk_load();
    chk("ld_pulse", 32'(LOAD_O), 32'd1);
    if (LOAD_O && sb.size() > 0) chk("ld_data", DATA_O, sb.pop_front());
  endtask

  task automatic req_pulse();
    REQ_I = 1'b1;
    tick();
    REQ_I = 1'b0;
    chk_load();
    tick();
    chk("ld_single", 32'(LOAD_O), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{32'h1, 1'b0, 5'd0, 1'b0};
    vt[1] = '{32'h2, 1'b0, 5'd0, 1'b0};
    vt[2] = '{32'h3, 1'b1, 5'd7, 1'b0};
    vt[3] = '{32'h4, 1'b0, 5'd0, 1'b0};
    vt[4] = '{32'h5, 1'b0, 5'd0, 1'b1};

    RST_NI = 1'b0; EN_I = 1'b0; MODE_I = 1'b0; TRG_DELAY_I = '0;
    STORE_I = 1'b0; DATA_I = '0; TRG_EVENT_I = 1'b0; EVENT_POS_I = '0; REQ_I = 1'b0;
    HOST_WVALID_I = 1'b0; HOST_WDATA_I = '0; HOST_RREADY_I = 1'b0;
    tick();
    tick();
    chk("rst_done",   32'(DONE_O), 32'd0);
    chk("rst_rvalid", 32'(HOST_RVALID_O), 32'd0);
    chk("rst_load",   32'(LOAD_O), 32'd0);
    chk("rst_wready", 32'(HOST_WREADY_O), 32'd0);
    chk("rst_data",   DATA_O, 32'd0);
    chk("rst_wrap",   32'(WRAPPED_O), 32'd0);
    RST_NI = 1'b1;

    // Capture, delay 2, trigger on the third word
    start_mode(1'b0, 3'd2);
    for (int i = 0; i < 5; i++) begin
      store_word(vt[i].data, vt[i].trg, vt[i].pos, 1'b1);
      chk("cap_done", 32'(DONE_O), 32'(vt[i].exp_done));
    end
    chk("cap_taddr", 32'(TRG_ADDR_O), 32'd2);
    chk("cap_tpos",  32'(TRG_POS_O), 32'd7);
    chk("cap_wrap",  32'(WRAPPED_O), 32'd0);
    store_word(32'h99, 1'b0, 5'd0, 1'b0);
    drain(1'b0, 20);
    chk("cap_end_rv",  32'(HOST_RVALID_O), 32'd0);
    chk("cap_end_dn",  32'(DONE_O), 32'd1);

    // Wrap, delay 1, random readout stalls
    start_mode(1'b0, 3'd1);
    for (int i = 1; i <= 12; i++) begin
      store_word(32'(i), i == 11, 5'd1, 1'b1);
      if (i == 11) chk("wrap_post", 32'(DONE_O), 32'd0);
    end
    chk("wrap_done",  32'(DONE_O), 32'd1);
    chk("wrap_flag",  32'(WRAPPED_O), 32'd1);
    chk("wrap_taddr", 32'(TRG_ADDR_O), 32'd2);
    drain(1'b1, 100);
    chk("wrap_end_rv", 32'(HOST_RVALID_O), 32'd0);

    // Stream: three single requests, then a two-cycle request
    start_mode(1'b1, 3'd0);
    chk("str_wready", 32'(HOST_WREADY_O), 32'd1);
    chk("str_nodone", 32'(DONE_O), 32'd0);
    push_word(32'hA); push_word(32'hB); push_word(32'hC);
    for (int i = 0; i < 3; i++) req_pulse();
    chk("str_nounder", 32'(UNDERRUN_O), 32'd0);
    push_word(32'h11); push_word(32'h12);
    REQ_I = 1'b1;
    tick();
    chk_load();
    tick();
    chk("hold_one", 32'(LOAD_O), 32'd0);
    REQ_I = 1'b0;
    tick();
    chk("hold_none", 32'(LOAD_O), 32'd0);
    chk("data_hold", DATA_O, 32'h11);
    req_pulse();

    // Underrun: request on empty FIFO is served right after the first push
    REQ_I = 1'b1;
    tick();
    REQ_I = 1'b0;
    chk("und_noload", 32'(LOAD_O), 32'd0);
    chk("und_flag",   32'(UNDERRUN_O), 32'd1);
    tick();
    chk("und_pend",   32'(LOAD_O), 32'd0);
    push_word(32'hD);
    chk("und_edge_t", 32'(LOAD_O), 32'd0);
    tick();
    chk_load();

    // Full FIFO: ninth push held until a pop frees a slot
    tick();
    for (int i = 0; i < DEPTH; i++) push_word(32'h100 + 32'(i));
    chk("full_wready", 32'(HOST_WREADY_O), 32'd0);
    HOST_WVALID_I = 1'b1; HOST_WDATA_I = 32'h108;
    tick();
    chk("full_held", 32'(HOST_WREADY_O), 32'd0);
    REQ_I = 1'b1;
    tick();
    REQ_I = 1'b0;
    chk_load();
    chk("full_reopen", 32'(HOST_WREADY_O), 32'd1);
    if (HOST_WREADY_O) sb.push_back(32'h108);
    tick();
    HOST_WVALID_I = 1'b0;
    for (int i = 0; i < DEPTH; i++) req_pulse();
    chk("full_sb_empty", 32'(sb.size()), 32'd0);

    // Reset in POST, then re-arm with delay 0 and a single triggered store
    start_mode(1'b0, 3'd3);
    store_word(32'h1, 1'b0, 5'd0, 1'b0);
    store_word(32'h2, 1'b1, 5'd5, 1'b0);
    RST_NI = 1'b0;
    tick();
    chk("rp_done",  32'(DONE_O), 32'd0);
    chk("rp_taddr", 32'(TRG_ADDR_O), 32'd0);
    chk("rp_tpos",  32'(TRG_POS_O), 32'd0);
    chk("rp_wrap",  32'(WRAPPED_O), 32'd0);
    chk("rp_under", 32'(UNDERRUN_O), 32'd0);
    chk("rp_rv",    32'(HOST_RVALID_O), 32'd0);
    chk("rp_data",  DATA_O, 32'd0);
    RST_NI = 1'b1; TRG_DELAY_I = 3'd0;
    tick();
    cap_q.delete();
    store_word(32'h77, 1'b1, 5'd3, 1'b1);
    chk("rearm_done",  32'(DONE_O), 32'd1);
    chk("rearm_taddr", 32'(TRG_ADDR_O), 32'd0);
    chk("rearm_tpos",  32'(TRG_POS_O), 32'd3);
    drain(1'b0, 10);
    chk("rearm_rv", 32'(HOST_RVALID_O), 32'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule

// File: doc/trace_ring_buffer.md
Name: trace_ring_buffer

Overview:
- Memory-side stage directly behind the Tracer; consumes its STORE/DATA/trigger outputs and answers its REQ with LOAD/DATA.
- Capture mode (MODE_I=0): ring buffer of trace words with trigger bookkeeping and a post-trigger delay, then host readout oldest-first.
- Stream mode (MODE_I=1): host-filled FIFO drained by Tracer requests.

Parameters:
- DEPTH, 64, number of TRB_WIDTH-bit words; power of two, ≥4.
- AW, $clog2(DEPTH), address/pointer width (derived, not overridden).

Ports:
- CLK_I  in  1  clock.
- RST_NI  in  1  synchronous, active-low reset.
- EN_I  in  1  enable; low returns block to IDLE.
- MODE_I  in  1  0=capture, 1=stream; sampled only on IDLE exit.
- TRG_DELAY_I  in  AW  words stored after trigger word; max DEPTH-1.
- STORE_I  in  1  Tracer word valid.
- DATA_I  in  TRB_WIDTH  Tracer word.
- TRG_EVENT_I  in  1  Tracer trigger-seen level.
- EVENT_POS_I  in  $clog2(TRB_WIDTH)  bit position of trigger in word.
- REQ_I  in  1  Tracer word request (stream).
- DATA_O  out  TRB_WIDTH  word to Tracer.
- LOAD_O  out  1  DATA_O valid, one-cycle pulse.
- HOST_WVALID_I / HOST_WDATA_I[TRB_WIDTH] / HOST_WREADY_O  host push (stream).
- HOST_RVALID_O / HOST_RDATA_O[TRB_WIDTH] / HOST_RREADY_I  host readout (capture).
- DONE_O  out  1  capture complete.
- TRG_ADDR_O  out  AW  address of trigger word.
- TRG_POS_O  out  $clog2(TRB_WIDTH)  latched EVENT_POS_I.
- WRAPPED_O  out  1  sticky, write pointer wrapped.
- UNDERRUN_O  out  1  sticky, REQ_I seen with FIFO empty.

Behaviour:
- Reset (RST_NI=0 at edge): state IDLE; all outputs 0; pointers, counters, sticky flags cleared; memory contents not cleared. Mid-operation reset takes effect at the same edge.
- States: IDLE, ARMED, POST, DONE, STREAM. EN_I=0 in any state -> IDLE next edge, same clearing as reset.
- IDLE: EN_I=1 -> ARMED (MODE_I=0) or STREAM (MODE_I=1).
- ARMED: STORE_I writes DATA_I to mem[wp], wp+1 mod DEPTH, fill=min(fill+1,DEPTH); wp wrap to 0 sets WRAPPED_O. If STORE_I && TRG_EVENT_I: latch TRG_ADDR_O=wp, TRG_POS_O=EVENT_POS_I, post_cnt=TRG_DELAY_I; -> DONE if TRG_DELAY_I==0, else POST. TRG_EVENT_I without STORE_I ignored.
- POST: each STORE_I writes as above and decrements post_cnt; store with post_cnt==1 -> DONE. Trigger word is never overwritten.
- DONE: DONE_O=1; STORE_I ignored. Readout from rp = WRAPPED_O ? wp : 0, remaining=fill. HOST_RVALID_O=1 while remaining>0 with HOST_RDATA_O=mem[rp]; RVALID&&RREADY advances rp mod DEPTH, remaining-1. RDATA stable while RVALID&&!RREADY. Internal RAM read latency is hidden via prefetch; first RVALID no later than 2 cycles after DONE entry. After the last word RVALID=0; stay DONE until EN_I low.
- STREAM: FIFO of DEPTH words. HOST_WREADY_O = count<DEPTH; push on WVALID&&WREADY.
  - Request registered when REQ_I=1, LOAD_O=0 and none outstanding; at most one outstanding.
  - Outstanding request with count>0 (count as of previous edge): next edge LOAD_O=1, DATA_O=mem[rp], rp+1, count-1.
  - Registered request with FIFO empty sets UNDERRUN_O and stays pending; served the cycle after first push.
  - Latency REQ_I->LOAD_O exactly 1 cycle when non-empty.
  - Simultaneous push and pop: count unchanged.
  - DATA_O holds its last value when LOAD_O=0.
- Capture-mode outputs LOAD_O, HOST_WREADY_O = 0; stream-mode HOST_RVALID_O, DONE_O = 0.

Decomposition:
- DTB_PKG: add TRB_DEPTH, TRB_ADDR_BITS, typedef enum trb_state_t {IDLE, ARMED, POST, DONE, STREAM}.
- Sub-module trace_bram: simple dual-port sync RAM (1 write, 1 registered read, no reset) for BRAM inference; shared by both modes.

Test Plan:
- DEPTH=8, TRB_WIDTH=32. Capture, delay 2: store 0x1..0x5, trigger on 0x3 with EVENT_POS_I=7 -> DONE_O after 0x5, TRG_ADDR_O=2, TRG_POS_O=7, WRAPPED_O=0, readout 0x1..0x5, then RVALID=0.
- Wrap, delay 1: store 0x1..0xC, trigger on 0xB -> DONE after 0xC, WRAPPED_O=1, TRG_ADDR_O=2, readout 0x5..0xC with random RREADY stalls.
- Stream: push 0xA,0xB,0xC; three REQ_I pulses -> LOAD_O exactly 1 cycle after each with DATA_O=0xA,0xB,0xC; REQ_I held 2 cycles yields one LOAD_O.
- Underrun: REQ_I with empty FIFO -> no LOAD_O, UNDERRUN_O=1; push 0xD at edge t -> LOAD_O=1, DATA_O=0xD at edge t+1.
- Full: push 8 words -> HOST_WREADY_O=0, 9th held; one pop -> WREADY=1 next cycle, 9th accepted, order preserved.
- RST_NI=0 one cycle during POST -> all outputs 0, IDLE; re-arm with delay 0, single store with trigger -> DONE, fill=1.
